lsb_message_extractor: RTL and testbench
========================================

Name: lsb_message_extractor

Overview:
- Receive-side counterpart of the transmitter's bit changer. Sits directly downstream of the UART-to-sample assembler on the decoding board and consumes its 24-bit sample strobes.
- Recovers the hidden message from bit BIT_POS of consecutive samples and passes each sample through unchanged.
- Streams each completed message, byte by byte, to a uart_tx instance for readout.

Parameters:
- BPS, 24, sample width in bits.
- MESSAGE_LENGTH, 88, message length in bits; must be a multiple of 8 and at least 8.
- BIT_POS, 0, index of the carrier bit within a sample; must be less than BPS.

Ports:
- in_clk, input, 1, system clock (61.44 MHz domain).
- in_reset, input, 1, asynchronous active-high reset.
- in_enable, input, 1, one-cycle strobe: in_frame is valid.
- in_frame, input, BPS, received sample.
- in_clear, input, 1, synchronous resync: restart bit assembly.
- in_tx_busy, input, 1, out_Tx_Active of the downstream uart_tx.
- out_frame, output, BPS, registered copy of in_frame.
- out_ready, output, 1, one-cycle strobe qualifying out_frame.
- out_message, output, MESSAGE_LENGTH, last completed message; MSB is the first bit received.
- out_message_valid, output, 1, one-cycle pulse when out_message updates.
- out_bit_count, output, 8, number of bits assembled so far in the current message.
- out_tx_byte, output, 8, byte presented to uart_tx.
- out_tx_dv, output, 1, one-cycle strobe to uart_tx in_Tx_DV.
- out_overrun, output, 1, one-cycle pulse when a completed message is not queued for sending.

Behaviour:
- Reset (async assert, sync release): every output is 0; the shift register is 0; the FSM is in S_IDLE.
- Passthrough: out_frame <= in_frame and out_ready <= in_enable. Latency is exactly 1 cycle; no stalling.
- Assembly, on each in_enable:
  - shift <= {shift[MESSAGE_LENGTH-2:0], in_frame[BIT_POS]}.
  - bit count increments.
- Completion: when the count reaches MESSAGE_LENGTH-1 and in_enable is high, on the same edge:
  - out_message <= the completed shift value.
  - out_message_valid <= 1 for one cycle.
  - The bit count wraps to 0.
- in_clear:
  - Clears the count and shift register next cycle; out_message is not touched.
  - in_clear has priority over a simultaneous in_enable; that sample is passed through but not assembled.
- Send FSM states:
  - S_IDLE: on a completion, snapshot the message into the send register, set byte index to 0, go to S_LOAD.
  - S_LOAD: wait while in_tx_busy=1. When in_tx_busy=0, drive out_tx_byte = snapshot[MESSAGE_LENGTH-1-8*idx -: 8] and pulse out_tx_dv for one cycle, then go to S_WAIT_ACTIVE.
  - S_WAIT_ACTIVE: wait for in_tx_busy=1, then go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for in_tx_busy=0. If idx = MESSAGE_LENGTH/8-1, go to S_IDLE; else increment idx and go to S_LOAD.
- Bytes are sent most-significant first. out_tx_byte holds its value until the next load.
- Completion while the FSM is not in S_IDLE:
  - out_message and out_message_valid update normally.
  - The snapshot is not changed; out_overrun pulses for 1 cycle.
  - The in-flight transfer finishes untouched.
- Completion in the same cycle the FSM returns to S_IDLE: not an overrun; the FSM picks it up on the next cycle.
- Widths: the byte index is $clog2(MESSAGE_LENGTH/8) bits wide, minimum 1. out_bit_count is zero-extended or truncated to 8 bits.
- Reset mid-transfer: the FSM returns to S_IDLE and out_tx_dv drops immediately. The partial uart frame is abandoned.

Test Plan:
- Passthrough: pulse in_enable with in_frame=24'hABCDEF -> exactly one cycle later, out_frame=24'hABCDEF and out_ready=1 for 1 cycle.
- Extraction: feed 88 samples whose bit 0 carries 88'h4B6F6368616D5A414D5046 MSB-first, other bits random -> out_message=88'h4B6F6368616D5A414D5046, one out_message_valid pulse, out_bit_count returns to 0.
- UART stream: same message with a uart_tx model (busy rises 2 cycles after dv, stays high 10*640 cycles) -> 11 out_tx_dv pulses with bytes 4B,6F,63,68,61,6D,5A,41,4D,50,46 in order, then S_IDLE.
- Overrun: complete a second message while byte 3 of the first is in flight -> out_overrun pulses once, out_message shows the second message, the UART byte sequence of the first is uncorrupted.
- Resync: after 40 bits assert in_clear, then feed 88 fresh bits -> out_bit_count=0 after the clear, and exactly one completion carrying only the fresh bits.
- Async reset: assert in_reset between clock edges during S_WAIT_DONE -> all outputs 0 before the next edge, no further out_tx_dv, and normal operation after release.

Source files
------------

// File: rtl/lsb_message_extractor.sv
// -----------------------------------------------------------------------------
// lsb_message_extractor
//
// Receive-side recovery of a message hidden in one carrier bit of a sample
// stream. Every sample passes through unchanged with one cycle of latency.
// Carrier bits are assembled MSB-first into MESSAGE_LENGTH-bit messages. Each
// completed message is streamed byte by byte, most significant byte first, to a
// downstream uart_tx.
//
// Ports
//   in_clk            system clock
//   in_reset          asynchronous active-high reset
//   in_enable         strobe: in_frame holds a valid sample
//   in_frame          received sample (BPS bits)
//   in_clear          synchronous resync: restart bit assembly
//   in_tx_busy        uart_tx active flag
//   out_frame         registered copy of in_frame
//   out_ready         strobe qualifying out_frame
//   out_message       last completed message; MSB is the first bit received
//   out_message_valid one-cycle pulse when out_message updates
//   out_bit_count     bits assembled so far in the current message
//   out_tx_byte       byte presented to uart_tx; held until the next load
//   out_tx_dv         one-cycle data-valid strobe to uart_tx
//   out_overrun       one-cycle pulse when a completed message is not queued
// -----------------------------------------------------------------------------
module lsb_message_extractor #(
    parameter int BPS            = 24,
    parameter int MESSAGE_LENGTH = 88,
    parameter int BIT_POS        = 0
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic                      in_enable,
    input  logic [BPS-1:0]            in_frame,
    input  logic                      in_clear,
    input  logic                      in_tx_busy,
    output logic [BPS-1:0]            out_frame,
    output logic                      out_ready,
    output logic [MESSAGE_LENGTH-1:0] out_message,
    output logic                      out_message_valid,
    output logic [7:0]                out_bit_count,
    output logic [7:0]                out_tx_byte,
    output logic                      out_tx_dv,
    output logic                      out_overrun
);

    localparam int NUM_BYTES = MESSAGE_LENGTH / 8;
    localparam int IW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CW        = $clog2(MESSAGE_LENGTH);

    localparam logic [CW-1:0] LAST_COUNT = CW'(MESSAGE_LENGTH - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACTIVE,
        S_WAIT_DONE
    } state_t;

    // Registered state
    logic [BPS-1:0]            frame_q,         frame_d;
    logic                      ready_q,         ready_d;
    logic [MESSAGE_LENGTH-1:0] shift_q,         shift_d;
    logic [CW-1:0]             count_q,         count_d;
    logic [MESSAGE_LENGTH-1:0] message_q,       message_d;
    logic                      message_valid_q, message_valid_d;
    logic                      overrun_q,       overrun_d;
    state_t                    state_q,         state_d;
    logic [IW-1:0]             idx_q,           idx_d;
    logic [MESSAGE_LENGTH-1:0] snap_q,          snap_d;
    logic [7:0]                tx_byte_q,       tx_byte_d;
    logic                      tx_dv_q,         tx_dv_d;
    // A completion that lands on the cycle the FSM returns to idle is
    // remembered here and picked up on the following cycle.
    logic                      pending_q,       pending_d;

    logic [MESSAGE_LENGTH-1:0] completed;
    logic                      complete;
    logic                      returning;
    logic [7:0]                snap_bytes [NUM_BYTES];

    assign completed = {shift_q[MESSAGE_LENGTH-2:0], in_frame[BIT_POS]};
    assign complete  = in_enable && !in_clear && (count_q == LAST_COUNT);

    // Byte k of the snapshot, byte 0 being the most significant.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_snap_bytes
            assign snap_bytes[gi] = snap_q[MESSAGE_LENGTH-1-8*gi -: 8];
        end
    endgenerate

    // Passthrough and bit assembly
    always_comb begin
        frame_d         = in_frame;
        ready_d         = in_enable;
        shift_d         = shift_q;
        count_d         = count_q;
        message_d       = message_q;
        message_valid_d = 1'b0;
        if (in_clear) begin
            shift_d = '0;
            count_d = '0;
        end else if (in_enable) begin
            shift_d = completed;
            if (count_q == LAST_COUNT) begin
                count_d         = '0;
                message_d       = completed;
                message_valid_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Send FSM
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        pending_d = pending_q;
        overrun_d = 1'b0;
        returning = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (complete) begin
                    snap_d    = completed;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end else if (pending_q) begin
                    // out_message already holds the message that completed
                    // while the FSM was returning.
                    snap_d    = message_q;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!in_tx_busy) begin
                    tx_byte_d = snap_bytes[idx_q];
                    tx_dv_d   = 1'b1;
                    state_d   = S_WAIT_ACTIVE;
                end
            end
            S_WAIT_ACTIVE: begin
                if (in_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!in_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        returning = 1'b1;
                        state_d   = S_IDLE;
                        if (complete) begin
                            pending_d = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (complete && (state_q != S_IDLE) && !returning) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            frame_q         <= '0;
            ready_q         <= 1'b0;
            shift_q         <= '0;
            count_q         <= '0;
            message_q       <= '0;
            message_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
            state_q         <= S_IDLE;
            idx_q           <= '0;
            snap_q          <= '0;
            tx_byte_q       <= '0;
            tx_dv_q         <= 1'b0;
            pending_q       <= 1'b0;
        end else begin
            frame_q         <= frame_d;
            ready_q         <= ready_d;
            shift_q         <= shift_d;
            count_q         <= count_d;
            message_q       <= message_d;
            message_valid_q <= message_valid_d;
            overrun_q       <= overrun_d;
            state_q         <= state_d;
            idx_q           <= idx_d;
            snap_q          <= snap_d;
            tx_byte_q       <= tx_byte_d;
            tx_dv_q         <= tx_dv_d;
            pending_q       <= pending_d;
        end
    end

    generate
        if (CW >= 8) begin : g_count_trunc
            assign out_bit_count = count_q[7:0];
        end else begin : g_count_ext
            assign out_bit_count = {{(8-CW){1'b0}}, count_q};
        end
    endgenerate

    assign out_frame         = frame_q;
    assign out_ready         = ready_q;
    assign out_message       = message_q;
    assign out_message_valid = message_valid_q;
    assign out_tx_byte       = tx_byte_q;
    assign out_tx_dv         = tx_dv_q;
    assign out_overrun       = overrun_q;

endmodule

// File: tb/tb_lsb_message_extractor.sv
module tb_lsb_message_extractor;

    localparam int BPS      = 24;
    localparam int ML       = 88;
    localparam int NB       = ML / 8;
    localparam int BUSY_CYC = 40;

    logic          in_clk = 1'b0;
    logic          in_reset = 1'b1;
    logic          in_enable = 1'b0;
    logic [BPS-1:0] in_frame = '0;
    logic          in_clear = 1'b0;
    logic          in_tx_busy = 1'b0;
    logic [BPS-1:0] out_frame;
    logic          out_ready;
    logic [ML-1:0] out_message;
    logic          out_message_valid;
    logic [7:0]    out_bit_count;
    logic [7:0]    out_tx_byte;
    logic          out_tx_dv;
    logic          out_overrun;

    lsb_message_extractor #(.BPS(BPS), .MESSAGE_LENGTH(ML), .BIT_POS(0)) dut (
        .in_clk(in_clk),
        .in_reset(in_reset),
        .in_enable(in_enable),
        .in_frame(in_frame),
        .in_clear(in_clear),
        .in_tx_busy(in_tx_busy),
        .out_frame(out_frame),
        .out_ready(out_ready),
        .out_message(out_message),
        .out_message_valid(out_message_valid),
        .out_bit_count(out_bit_count),
        .out_tx_byte(out_tx_byte),
        .out_tx_dv(out_tx_dv),
        .out_overrun(out_overrun)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: carrier bits collected since the last restart,
    // messages completed, and the byte stream expected at the uart.
    bit          bq[$];
    logic [ML-1:0] exp_msgs[$];
    logic [7:0]  exp_bytes[$];

    // Observations
    logic [7:0]  got_bytes[$];
    int          valid_cnt = 0;
    int          ovr_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input logic [ML-1:0] m, input int k);
        logic [ML-1:0] t;
        t = m >> (8 * (NB - 1 - k));
        return t[7:0];
    endfunction

    task automatic expect_send(input logic [ML-1:0] m, input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_bytes.push_back(msg_byte(m, k));
    endtask

    task automatic feed_bit(input bit b);
        logic [31:0] r;
        logic [ML-1:0] m;
        @(negedge in_clk);
        r = $urandom;
        r[0] = b;
        in_enable = 1'b1;
        in_frame = r[BPS-1:0];
        bq.push_back(b);
        if (bq.size() == ML) begin
            m = '0;
            for (int i = 0; i < ML; i++) m = {m[ML-2:0], bq[i]};
            exp_msgs.push_back(m);
            bq.delete();
        end
    endtask

    task automatic idle();
        @(negedge in_clk);
        in_enable = 1'b0;
        in_clear = 1'b0;
    endtask

    task automatic feed_msg(input logic [ML-1:0] m);
        for (int i = ML - 1; i >= 0; i--) feed_bit(m[i]);
        idle();
    endtask

    function automatic logic [ML-1:0] rand_msg();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[ML-1:0];
    endfunction

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int c = 0;
        while (got_bytes.size() < n && c < budget) begin
            @(negedge in_clk);
            c++;
        end
        check(tag, 128'(got_bytes.size()), 128'(n));
    endtask

    // Output monitor
    initial begin
        forever begin
            @(negedge in_clk);
            if (out_tx_dv) got_bytes.push_back(out_tx_byte);
            if (out_message_valid) valid_cnt++;
            if (out_overrun) ovr_cnt++;
        end
    end

    // uart_tx model: busy rises 2 cycles after dv, stays high BUSY_CYC cycles
    initial begin
        forever begin
            @(negedge in_clk);
            if (out_tx_dv) begin
                repeat (2) @(posedge in_clk);
                #1 in_tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge in_clk);
                #1 in_tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_frame"}, 128'(out_frame), 128'(0));
        check({pfx, "_ready"}, 128'(out_ready), 128'(0));
        check({pfx, "_message"}, 128'(out_message), 128'(0));
        check({pfx, "_valid"}, 128'(out_message_valid), 128'(0));
        check({pfx, "_bit_count"}, 128'(out_bit_count), 128'(0));
        check({pfx, "_tx_byte"}, 128'(out_tx_byte), 128'(0));
        check({pfx, "_tx_dv"}, 128'(out_tx_dv), 128'(0));
        check({pfx, "_overrun"}, 128'(out_overrun), 128'(0));
    endtask

    logic [ML-1:0] m1, m2, m3, m4;
    int n_before;

    initial begin
        m1 = 88'h4B6F6368616D5A414D5046;

        // Reset state
        repeat (2) @(negedge in_clk);
        check_all_zero("reset");
        in_reset = 1'b0;

        // Passthrough: one sample, one-cycle latency
        @(negedge in_clk);
        in_enable = 1'b1;
        in_frame = 24'hABCDEF;
        bq.push_back(1'b1);
        idle();
        check("pass_frame", 128'(out_frame), 128'(24'hABCDEF));
        check("pass_ready", 128'(out_ready), 128'(1));
        @(negedge in_clk);
        check("pass_ready_drop", 128'(out_ready), 128'(0));
        check("pass_count", 128'(out_bit_count), 128'(bq.size()));

        // Clear with simultaneous enable: passed through, not assembled
        @(negedge in_clk);
        in_clear = 1'b1;
        in_enable = 1'b1;
        in_frame = 24'h123457;
        bq.delete();
        idle();
        check("clr_frame", 128'(out_frame), 128'(24'h123457));
        check("clr_ready", 128'(out_ready), 128'(1));
        check("clr_count", 128'(out_bit_count), 128'(0));

        // Extraction of the reference message
        for (int i = ML - 1; i >= ML - 40; i--) feed_bit(m1[i]);
        idle();
        check("mid_count", 128'(out_bit_count), 128'(40));
        for (int i = ML - 41; i >= 0; i--) feed_bit(m1[i]);
        idle();
        check("m1_model", 128'(exp_msgs[$]), 128'(m1));
        check("m1_message", 128'(out_message), 128'(exp_msgs[$]));
        check("m1_valid_cnt", 128'(valid_cnt), 128'(1));
        check("m1_count_wrap", 128'(out_bit_count), 128'(0));
        expect_send(m1, NB);

        // Overrun: second message completes while the first is being sent
        wait_bytes(3, 400, "wait_m1_3bytes");
        m2 = rand_msg();
        feed_msg(m2);
        check("ovr_cnt", 128'(ovr_cnt), 128'(1));
        check("m2_valid_cnt", 128'(valid_cnt), 128'(2));
        check("m2_message", 128'(out_message), 128'(m2));
        wait_bytes(NB, 1500, "wait_m1_all");
        repeat (BUSY_CYC + 20) @(negedge in_clk);
        check("m1_no_extra", 128'(got_bytes.size()), 128'(NB));
        check("tx_byte_hold", 128'(out_tx_byte), 128'(msg_byte(m1, NB - 1)));

        // Resync: 40 bits, clear, then 88 fresh bits
        for (int i = 0; i < 40; i++) feed_bit($urandom_range(0, 1) == 1);
        idle();
        check("resync_pre", 128'(out_bit_count), 128'(40));
        @(negedge in_clk);
        in_clear = 1'b1;
        bq.delete();
        idle();
        check("resync_clear", 128'(out_bit_count), 128'(0));
        check("resync_msg_kept", 128'(out_message), 128'(m2));
        m3 = rand_msg();
        feed_msg(m3);
        check("m3_valid_cnt", 128'(valid_cnt), 128'(3));
        check("m3_message", 128'(out_message), 128'(m3));
        expect_send(m3, 2);

        // Async reset while the second byte of m3 is in flight
        wait_bytes(NB + 2, 400, "wait_m3_2bytes");
        begin
            int c = 0;
            while (!in_tx_busy && c < 20) begin
                @(negedge in_clk);
                c++;
            end
            check("m3_busy_seen", 128'(in_tx_busy), 128'(1));
        end
        repeat (3) @(negedge in_clk);
        @(posedge in_clk);
        #3 in_reset = 1'b1;
        #1;
        check_all_zero("arst");
        bq.delete();
        repeat (2) @(negedge in_clk);
        in_reset = 1'b0;
        n_before = got_bytes.size();
        repeat (BUSY_CYC + 10) @(negedge in_clk);
        check("arst_no_dv", 128'(got_bytes.size()), 128'(n_before));

        // Normal operation after release
        m4 = rand_msg();
        feed_msg(m4);
        check("m4_valid_cnt", 128'(valid_cnt), 128'(4));
        check("m4_message", 128'(out_message), 128'(m4));
        expect_send(m4, NB);
        wait_bytes(exp_bytes.size(), 1500, "wait_m4_all");
        repeat (BUSY_CYC + 20) @(negedge in_clk);
        check("total_bytes", 128'(got_bytes.size()), 128'(exp_bytes.size()));
        for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++) begin
            $display("byte %0d got %02h exp %02h", k, got_bytes[k], exp_bytes[k]);
            check($sformatf("byte%0d", k), 128'(got_bytes[k]), 128'(exp_bytes[k]));
        end
        check("ovr_final", 128'(ovr_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
